sync_debounce: RTL and testbench
================================

Name: sync_debounce

Overview:
- Parametrised multi-channel input conditioner for asynchronous external signals such as switches, buttons and async flags.
- Each channel passes through a configurable-depth flop synchronizer, then a per-channel stable-count debouncer.
- Produces the clean level plus one-cycle rise and fall pulses, all on the clock domain.
- Sits between board-level inputs and any FSM or I/O register logic that consumes them.

Parameters:
- WIDTH, 8, number of independent channels.
- STAGES, 2, synchronizer flop depth; legal values are 2 or more.
- DEBOUNCE, 4, consecutive cycles the synchronized value must differ from out before out changes; legal values are 1 or more.
- RESET_VALUE, 0 (WIDTH bits), value loaded into all synchronizer flops and out on reset.

Ports:
- clock, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high.
- in, input, WIDTH, asynchronous raw inputs.
- out, output, WIDTH, debounced synchronized level (registered).
- rise, output, WIDTH, one-cycle pulse per channel on the cycle out goes 0->1 (registered).
- fall, output, WIDTH, one-cycle pulse per channel on the cycle out goes 1->0 (registered).
- any_edge, output, 1, registered OR of all rise and fall bits; asserted in the same cycle as those bits.

Behaviour:
- One clock; reset is synchronous and active-high.
- On any edge with reset=1:
  - all STAGES sync flops and out load RESET_VALUE;
  - all counters load 0;
  - rise, fall and any_edge load 0.
  - Reset overrides every other update, including a mid-debounce count; no pulse is generated by reset itself.
- Synchronizer:
  - stage[0] <= in;
  - stage[i] <= stage[i-1];
  - s = stage[STAGES-1].
  - No logic is permitted between stages.
- Per-channel debounce, evaluated each edge when reset=0:
  - If s[c] == out[c]: cnt[c] <= 0; out[c] holds.
  - If s[c] != out[c] and cnt[c] == DEBOUNCE-1: out[c] <= s[c]; cnt[c] <= 0.
  - If s[c] != out[c] and cnt[c] < DEBOUNCE-1: cnt[c] <= cnt[c]+1.
- Counter width is max(1, clog2(DEBOUNCE)); the counter never exceeds DEBOUNCE-1 and has no wrap path.
- Pulses:
  - rise[c] <= 1 exactly on the edge where out[c] is loaded 0->1; otherwise 0.
  - fall[c] likewise for 1->0.
  - Pulses are one cycle wide and coincide with the first cycle of the new out value.
- Latency: if in[c] changes and stays stable from capture edge k onward, out[c], rise[c] and fall[c] update at edge k+STAGES+DEBOUNCE-1.
  - With defaults, that is k+5.
  - With STAGES=2 and DEBOUNCE=1, it is k+2.
- Glitches:
  - A disagreement at s lasting fewer than DEBOUNCE consecutive cycles leaves out unchanged and clears cnt.
  - No partial credit carries across interruptions.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses, and any_edge is a single 1 for that cycle.
- A change on in that reverts before stage[0] captures it is invisible; this is acceptable.
- out never toggles more often than once per DEBOUNCE cycles per channel.
- No combinational path from in to any output.

Test Plan:
- Reset with RESET_VALUE=8'hA5, defaults otherwise: assert reset 1 cycle with in=8'h00 -> out=8'hA5, rise=fall=0, any_edge=0. Then after STAGES+DEBOUNCE-1=5 edges of in=0 -> out=8'h00, fall=8'hA5 for exactly one cycle, any_edge=1 that cycle.
- Clean step, defaults: in[0] 0->1 captured at edge 10, held -> out[0]=1 and rise[0]=1 at edge 15 only; rise[0]=0 at edge 16; fall stays 0.
- Glitch rejection, DEBOUNCE=4: in[3] high for 3 cycles then low -> out[3] stays 0, no pulses. Repeat with in[3] high 3, low 1, high 3 -> still no change. Then high 4 -> out[3]=1 with rise[3] pulse.
- Minimum configuration, STAGES=2, DEBOUNCE=1: toggle in[1] every 2 cycles -> out[1] tracks with 2-edge latency; alternating rise[1]/fall[1] pulses each 2 cycles.
- Simultaneous multi-channel: in 8'h00->8'hF0 in one cycle -> rise=8'hF0 for one cycle and any_edge=1 once. Then in->8'h0F -> rise=8'h0F and fall=8'hF0 in the same cycle.
- Reset mid-operation: in[2] high for 2 cycles past sync (cnt[2]=2), assert reset one edge -> cnt cleared, out=RESET_VALUE, no pulse. After release with in[2] still high -> rise[2] asserted exactly STAGES+DEBOUNCE-1 edges after the first post-reset edge.

Source files
------------

// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: a flop synchronizer per channel followed by a
// stable-count debouncer producing a registered level, rise/fall pulses and an any-edge flag.
module sync_debounce #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      STAGES      = 2,
  parameter int unsigned      DEBOUNCE    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  localparam int unsigned      CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [WIDTH-1:0] sync_r    [STAGES];
  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] out_nxt_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;

  assign sync_s = sync_r[STAGES-1];

  // plain flop chain; nothing may sit between stages
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_r[i] <= RESET_VALUE;
    end else begin
      sync_r[0] <= in;
      for (int i = 1; i < STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // per-channel stable count: any agreement clears the count, so no partial credit survives a glitch
  always_comb begin
    out_nxt_s = out;
    for (int c = 0; c < WIDTH; c++) begin
      cnt_nxt_s[c] = CNT_ZERO;
      if (sync_s[c] != out[c]) begin
        if (cnt_r[c] == CNT_MAX) begin
          out_nxt_s[c] = sync_s[c];
        end else begin
          cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
        end
      end else begin
        cnt_nxt_s[c] = CNT_ZERO;
      end
    end
  end

  assign rise_s = out_nxt_s & ~out;
  assign fall_s = ~out_nxt_s & out;

  // registered level, pulses and counters; reset never produces a pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      out      <= RESET_VALUE;
      rise     <= {WIDTH{1'b0}};
      fall     <= {WIDTH{1'b0}};
      any_edge <= 1'b0;
      for (int c = 0; c < WIDTH; c++) cnt_r[c] <= CNT_ZERO;
    end else begin
      out      <= out_nxt_s;
      rise     <= rise_s;
      fall     <= fall_s;
      any_edge <= |(rise_s | fall_s);
      for (int c = 0; c < WIDTH; c++) cnt_r[c] <= cnt_nxt_s[c];
    end
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: three instances (reset value A5, defaults, and the
// minimum STAGES=2/DEBOUNCE=1 configuration) driven with hand-computed expectations.
module tb_sync_debounce;

  logic       clock = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic       rst_a, rst_d, rst_m;
  logic [7:0] in_a, in_d, in_m;
  logic [7:0] out_a, rise_a, fall_a, out_d, rise_d, fall_d, out_m, rise_m, fall_m;
  logic       any_a, any_d, any_m;
  logic [0:23] glitch_pat;

  always #5 clock = ~clock;

  sync_debounce #(.WIDTH(8), .STAGES(2), .DEBOUNCE(4), .RESET_VALUE(8'hA5)) dut_a (
    .clock(clock), .reset(rst_a), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .any_edge(any_a));

  sync_debounce #(.WIDTH(8), .STAGES(2), .DEBOUNCE(4), .RESET_VALUE(8'h00)) dut_d (
    .clock(clock), .reset(rst_d), .in(in_d), .out(out_d), .rise(rise_d), .fall(fall_d), .any_edge(any_d));

  sync_debounce #(.WIDTH(8), .STAGES(2), .DEBOUNCE(1), .RESET_VALUE(8'h00)) dut_m (
    .clock(clock), .reset(rst_m), .in(in_m), .out(out_m), .rise(rise_m), .fall(fall_m), .any_edge(any_m));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e_out, e_fall;
    logic       e_any;
    rst_a = 1'b1; rst_d = 1'b1; rst_m = 1'b1;
    in_a = 8'h00; in_d = 8'h00; in_m = 8'h00;
    tick();
    checks++; if (out_a !== 8'hA5) begin errors++; $display("FAIL reset_out_a: got %h want a5", out_a); end
    checks++; if ((rise_a | fall_a) !== 8'h00 || any_a !== 1'b0) begin errors++; $display("FAIL reset_pulses_a: rise %h fall %h any %b want 0", rise_a, fall_a, any_a); end
    checks++; if (out_d !== 8'h00 || (rise_d | fall_d) !== 8'h00 || any_d !== 1'b0) begin errors++; $display("FAIL reset_d: out %h rise %h fall %h any %b want 0", out_d, rise_d, fall_d, any_d); end
    checks++; if (out_m !== 8'h00 || (rise_m | fall_m) !== 8'h00 || any_m !== 1'b0) begin errors++; $display("FAIL reset_m: out %h rise %h fall %h any %b want 0", out_m, rise_m, fall_m, any_m); end
    rst_a = 1'b0; rst_d = 1'b0; rst_m = 1'b0;
    // first post-reset edge captures in=0; out follows 5 edges later
    for (int j = 1; j <= 7; j++) begin
      tick();
      e_out  = (j < 6) ? 8'hA5 : 8'h00;
      e_fall = (j == 6) ? 8'hA5 : 8'h00;
      e_any  = (j == 6);
      checks++; if (out_a !== e_out || fall_a !== e_fall || rise_a !== 8'h00 || any_a !== e_any) begin
        errors++; $display("FAIL reset_release edge %0d: out %h fall %h rise %h any %b want out %h fall %h rise 00 any %b", j, out_a, fall_a, rise_a, any_a, e_out, e_fall, e_any);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [7:0] e_out, e_rise;
    in_d = 8'h01;
    for (int j = 0; j <= 6; j++) begin
      tick();
      e_out  = (j >= 5) ? 8'h01 : 8'h00;
      e_rise = (j == 5) ? 8'h01 : 8'h00;
      checks++; if (out_d !== e_out || rise_d !== e_rise || fall_d !== 8'h00 || any_d !== (j == 5)) begin
        errors++; $display("FAIL clean_step k+%0d: out %h rise %h fall %h any %b want out %h rise %h fall 00", j, out_d, rise_d, fall_d, any_d, e_out, e_rise);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] e_out, e_rise;
    glitch_pat = 24'b1110000000_11101110000000;
    for (int j = 0; j < 24; j++) begin
      in_d = {4'b0000, glitch_pat[j], 3'b001};
      tick();
      checks++; if (out_d !== 8'h01 || (rise_d | fall_d) !== 8'h00) begin
        errors++; $display("FAIL glitch step %0d: out %h rise %h fall %h want out 01 no pulses", j, out_d, rise_d, fall_d);
      end
    end
    for (int j = 0; j <= 5; j++) begin
      in_d = (j < 4) ? 8'h09 : 8'h01;
      tick();
      e_out  = (j == 5) ? 8'h09 : 8'h01;
      e_rise = (j == 5) ? 8'h08 : 8'h00;
      checks++; if (out_d !== e_out || rise_d !== e_rise || fall_d !== 8'h00) begin
        errors++; $display("FAIL glitch_accept k+%0d: out %h rise %h fall %h want out %h rise %h fall 00", j, out_d, rise_d, fall_d, e_out, e_rise);
      end
    end
    for (int j = 0; j < 6; j++) tick();
    checks++; if (out_d !== 8'h01) begin errors++; $display("FAIL glitch_settle: out %h want 01", out_d); end
  endtask

  task automatic test_min_config();
    logic b_hist [12];
    logic e, prev;
    prev = 1'b0;
    for (int j = 0; j < 12; j++) begin
      b_hist[j] = (((j >> 1) & 1) == 0);
      in_m = {6'b000000, b_hist[j], 1'b0};
      tick();
      e = (j >= 2) ? b_hist[j-2] : 1'b0;
      checks++; if (out_m !== {6'b000000, e, 1'b0} || rise_m !== {6'b000000, e & ~prev, 1'b0} || fall_m !== {6'b000000, ~e & prev, 1'b0}) begin
        errors++; $display("FAIL min_config edge %0d: out %h rise %h fall %h want out bit1=%b rise bit1=%b fall bit1=%b", j, out_m, rise_m, fall_m, e, e & ~prev, ~e & prev);
      end
      prev = e;
    end
  endtask

  task automatic test_simultaneous();
    in_d = 8'h00;
    for (int j = 0; j < 10; j++) tick();
    in_d = 8'hF0;
    for (int j = 0; j <= 6; j++) begin
      tick();
      if (j == 4) begin
        checks++; if (rise_d !== 8'h00 || out_d !== 8'h00) begin errors++; $display("FAIL simul_early: out %h rise %h want 00 00", out_d, rise_d); end
      end else if (j == 5) begin
        checks++; if (rise_d !== 8'hF0 || fall_d !== 8'h00 || any_d !== 1'b1 || out_d !== 8'hF0) begin
          errors++; $display("FAIL simul_rise: out %h rise %h fall %h any %b want f0 f0 00 1", out_d, rise_d, fall_d, any_d); end
      end else if (j == 6) begin
        checks++; if (rise_d !== 8'h00 || any_d !== 1'b0) begin errors++; $display("FAIL simul_one_cycle: rise %h any %b want 00 0", rise_d, any_d); end
      end
    end
    in_d = 8'h0F;
    for (int j = 0; j <= 5; j++) begin
      tick();
      if (j == 4) begin
        checks++; if (any_d !== 1'b0 || out_d !== 8'hF0) begin errors++; $display("FAIL swap_early: out %h any %b want f0 0", out_d, any_d); end
      end else if (j == 5) begin
        checks++; if (rise_d !== 8'h0F || fall_d !== 8'hF0 || any_d !== 1'b1 || out_d !== 8'h0F) begin
          errors++; $display("FAIL swap: out %h rise %h fall %h any %b want 0f 0f f0 1", out_d, rise_d, fall_d, any_d); end
      end
    end
  endtask

  task automatic test_reset_mid();
    in_d = 8'h0B;
    for (int j = 0; j < 10; j++) tick();
    checks++; if (out_d !== 8'h0B) begin errors++; $display("FAIL mid_setup: out %h want 0b", out_d); end
    in_d = 8'h0F;
    for (int j = 0; j < 4; j++) tick();
    rst_d = 1'b1;
    tick();
    checks++; if (out_d !== 8'h00 || (rise_d | fall_d) !== 8'h00 || any_d !== 1'b0) begin
      errors++; $display("FAIL mid_reset: out %h rise %h fall %h any %b want 00 00 00 0", out_d, rise_d, fall_d, any_d); end
    rst_d = 1'b0;
    for (int j = 0; j <= 5; j++) begin
      tick();
      checks++; if (rise_d !== ((j == 5) ? 8'h0F : 8'h00) || out_d !== ((j == 5) ? 8'h0F : 8'h00) || fall_d !== 8'h00) begin
        errors++; $display("FAIL mid_recover k+%0d: out %h rise %h fall %h want out/rise %h fall 00", j, out_d, rise_d, fall_d, (j == 5) ? 8'h0F : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_min_config();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
